// File: rtl/gate_op_pkg.sv
// Shared definitions for the gate-op arbiter: opcode values and FSM states.
package gate_op_pkg;

    // Opcode encoding for the shared bitwise unit
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage : gate_op_pkg

// File: rtl/gate_op_unit.sv
// Combinational WIDTH-bit bitwise logic unit: y = f(op, a, b).
module gate_op_unit
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    // Select the bitwise function named by the opcode
    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            default: y_o = '0;
        endcase
    end

endmodule : gate_op_unit

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among N_REQ requesters.
// One transaction: grant (IDLE->EXEC), compute (EXEC->RESP), handshake (RESP->IDLE).
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a_in,
    input  logic [WIDTH*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   res_valid,
    output logic [WIDTH-1:0]       res_data,
    output logic [IDW-1:0]         res_id,
    input  logic                   res_ready,
    output logic                   busy
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [IDW-1:0]     win_q, win_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [IDW-1:0]     res_id_q, res_id_d;

    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;
    logic [IDW-1:0]     pick_next;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   unit_y;

    // Shared datapath works on the latched operands of the current winner
    gate_op_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (unit_y)
    );

    // Rotate-priority encode: first set request at or above rr_q, wrapping
    always_comb begin
        logic [IDW:0] cand;
        logic [IDW:0] nxt;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!pick_valid && req[cand[IDW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDW-1:0];
            end
        end
        nxt = {1'b0, pick_idx} + (IDW+1)'(1);
        if (nxt == (IDW+1)'(N_REQ)) begin
            nxt = '0;
        end
        pick_next = nxt[IDW-1:0];
    end

    // Operand/opcode mux for the candidate winner
    always_comb begin
        sel_op = op[2*int'(pick_idx) +: 2];
        sel_a  = a_in[WIDTH*int'(pick_idx) +: WIDTH];
        sel_b  = b_in[WIDTH*int'(pick_idx) +: WIDTH];
    end

    // Next-state and output-register logic; gnt defaults low so it pulses once
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        win_d       = win_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d           = pick_idx;
                    op_d            = sel_op;
                    a_d             = sel_a;
                    b_d             = sel_b;
                    gnt_d[pick_idx] = 1'b1;
                    rr_d            = pick_next;
                    state_d         = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = unit_y;
                res_id_d    = win_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule : gate_op_arbiter
